// File: rtl/mmio_ctrl_v2.sv
// mmio_ctrl_v2: I/O window at the top of the word-address space.
// Stores drive output regs; loads read synchronised inputs or RAM.
module mmio_ctrl_v2 #(
  parameter int addr_width = 10,
  parameter int data_width = 32,
  parameter int n_out      = 2,
  parameter int n_in       = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic                        rd_en,
  input  logic [addr_width-1:0]       addr,
  input  logic [data_width-1:0]       wr_data,
  input  logic [data_width-1:0]       mem_rd_data,
  input  logic [n_in*data_width-1:0]  phys_in,
  output logic                        mem_we,
  output logic                        mem_re,
  output logic [n_out*data_width-1:0] out_data,
  output logic [data_width-1:0]       rd_data,
  output logic                        rd_valid,
  output logic                        io_err
);

  localparam int DW = data_width;
  localparam logic [4:0] NO = 5'(n_out);
  localparam logic [4:0] NI = 5'(n_in);

  logic [5:0] off;
  logic [1:0] grp;
  logic [3:0] idx;
  logic       win;
  logic       rd_ok;
  logic       out_hit;
  logic       lvl_hit;
  logic       evt_hit;
  logic       bad;

  logic [n_in*DW-1:0]  s1;
  logic [n_in*DW-1:0]  s2;
  logic [n_in*DW-1:0]  s3;
  logic [n_in*DW-1:0]  evt;
  logic [n_in*DW-1:0]  set;
  logic [n_in*DW-1:0]  clr;
  logic [n_out*DW-1:0] out_q;

  logic [DW-1:0] out_sel;
  logic [DW-1:0] lvl_sel;
  logic [DW-1:0] evt_sel;
  logic [DW-1:0] io_nxt;
  logic [DW-1:0] rd_io_q;
  logic          rd_mem;

  // TOP - addr is the bitwise complement when TOP is all ones
  assign off = ~addr[5:0];
  assign win = &addr[addr_width-1:6];
  assign grp = off[5:4];
  assign idx = off[3:0];

  assign rd_ok   = rd_en & ~wr_en;
  assign out_hit = win & (grp == 2'd0) & ({1'b0, idx} < NO);
  assign lvl_hit = win & (grp == 2'd1) & ({1'b0, idx} < NI);
  assign evt_hit = win & (grp == 2'd2) & ({1'b0, idx} < NI);
  assign bad     = win & ~out_hit & ~lvl_hit & ~evt_hit;

  assign mem_we = wr_en & ~win;
  assign mem_re = rd_ok & ~win;

  assign set = s2 & ~s3;

  always_comb begin
    out_sel = '0;
    lvl_sel = '0;
    evt_sel = '0;
    clr     = '0;
    for (int k = 0; k < n_out; k++)
      if (idx == 4'(k))
        out_sel = out_q[k*DW +: DW];
    for (int j = 0; j < n_in; j++)
      if (idx == 4'(j)) begin
        lvl_sel = s2[j*DW +: DW];
        evt_sel = evt[j*DW +: DW] | set[j*DW +: DW];
        if (rd_ok & evt_hit)
          clr[j*DW +: DW] = {DW{1'b1}};
      end
  end

  always_comb begin
    io_nxt = '0;
    unique case (1'b1)
      out_hit: io_nxt = out_sel;
      lvl_hit: io_nxt = lvl_sel;
      evt_hit: io_nxt = evt_sel;
      default: io_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      s2       <= '0;
      s3       <= '0;
      evt      <= '0;
      out_q    <= '0;
      rd_valid <= 1'b0;
      io_err   <= 1'b0;
      rd_mem   <= 1'b0;
      rd_io_q  <= '0;
    end else begin
      s1       <= phys_in;
      s2       <= s1;
      s3       <= s2;
      evt      <= (evt & ~clr) | set;
      rd_valid <= rd_ok;
      io_err   <= (wr_en & win & ~out_hit)
                | (rd_ok & bad);
      if (rd_ok) begin
        rd_mem  <= ~win;
        rd_io_q <= io_nxt;
      end
      if (wr_en & out_hit)
        for (int k = 0; k < n_out; k++)
          if (idx == 4'(k))
            out_q[k*DW +: DW] <= wr_data;
    end
  end

  assign rd_data  = rd_mem ? mem_rd_data : rd_io_q;
  assign out_data = out_q;

endmodule

// File: doc/mmio_ctrl_v2.md
# mmio_ctrl_v2

Parametrised memory-mapped I/O controller between the core's data-memory port and the board peripherals. It decodes a configurable I/O window at the top of the address space. Stores into that window go to `n_out` registered output channels (seven-segment, LEDs). Loads from it return `n_in` synchronised input channels (buttons, switches), either as levels or as sticky rising-edge events cleared on read. All other accesses pass through to the synchronous data RAM, and both read paths share a single 1-cycle read handshake.

## Interface
Parameters:
- `addr_width`, 10: word-address width.
- `data_width`, 32: data and channel width.
- `n_out`, 2: output channels, 1..16.
- `n_in`, 1: input channels, 1..16.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserts immediately, releases on a clk edge.
- `wr_en`  in  1  store request, single cycle.
- `rd_en`  in  1  load request, single cycle.
- `addr`  in  addr_width  word address.
- `wr_data`  in  data_width  store data.
- `mem_rd_data`  in  data_width  RAM read data; valid the cycle after `mem_re`.
- `phys_in`  in  n_in*data_width  asynchronous peripheral inputs; channel j at bits [j*data_width +: data_width].
- `mem_we`  out  1  RAM write enable (combinational).
- `mem_re`  out  1  RAM read enable (combinational).
- `out_data`  out  n_out*data_width  output channel registers; channel k at bits [k*data_width +: data_width].
- `rd_data`  out  data_width  load result.
- `rd_valid`  out  1  `rd_data` valid this cycle.
- `io_err`  out  1  1-cycle pulse on an illegal I/O-window access.

## Operation
- Let TOP = 2^addr_width − 1. I/O window = addr ≥ TOP − 63. Outside the window, all accesses are memory accesses.
- Address map:
  - Output channel k at TOP − k.
  - Input level j at TOP − 16 − j.
  - Input event j at TOP − 32 − j.
  - Every other window address is unmapped.
- Defaults (addr_width=10): out0 = 0x3ff, out1 = 0x3fe, in0 level = 0x3ef, in0 event = 0x3df.
- Write priority:
  - If `wr_en` and `rd_en` are both 1, the write executes and the read is dropped.
  - A dropped read produces no `rd_valid` and no `mem_re`.
- `mem_we` = wr_en & !window. `mem_re` = rd_en & !wr_en & !window.
- Writes:
  - A mapped output address loads `wr_data` into that channel at the next edge.
  - A write to an input or unmapped window address changes nothing and pulses `io_err` next cycle.
- Input path:
  - Each bit of `phys_in` passes through a 2-flop synchroniser (s1, s2), then a history flop s3.
  - Per-bit event = s2 & ~s3. It ORs into the sticky register `evt[j]` each cycle.
- Reads (registered, 1-cycle latency):
  - Edge registers `rd_src` (MEM/IO) and `rd_io_q`.
  - `rd_data` = rd_src==MEM ? mem_rd_data : rd_io_q.
  - Level read: `rd_io_q` ← s2[j].
  - Event read: `rd_io_q` ← evt[j], and evt[j] is cleared at the same edge. Bits whose event is being set in that same cycle stay set (set wins), and they are also returned.
  - Output-address read: `rd_io_q` ← out register (readback), no error.
  - Unmapped read: `rd_io_q` ← 0, and `io_err` pulses.
- Reset values: `out_data` 0, s1/s2/s3 0, `evt` 0, `rd_valid` 0, `io_err` 0, `rd_src` IO, `rd_io_q` 0. Therefore `rd_data` = 0 during reset.
- Because s3 resets to 0, an input already high at reset release registers one rising event.
- Reset asserted mid-operation: a pending `rd_valid` or `io_err` is squashed, and all registers return to their reset values immediately.

## Timing
- A load accepted at edge t gives `rd_valid` = 1 during cycle t+1 with correct `rd_data`, for both memory and I/O. Back-to-back loads sustain 1 per cycle.
- Store to output: `out_data` updates at the accepting edge and is visible in cycle t+1.
- `io_err` is asserted exactly in cycle t+1 for the offending access accepted at edge t.
- A `phys_in` change meeting setup before edge e:
  - is in s2 after edge e+1;
  - is readable by a level read accepted at edge e+2;
  - for a rising bit, sets `evt` at edge e+2, visible to an event read accepted at edge e+3 or later.
- Inputs are not debounced; glitches wider than one clock can create events.

## Test plan
- Reset, then store 0x0000_00AB to 0x3ff and 0x0000_1234 to 0x3fe -> `out_data` ch0 = 0xAB and ch1 = 0x1234 next cycle; `mem_we` stays 0; readback of 0x3fe gives 0x1234 with `rd_valid` one cycle later.
- Store 0xDEAD to 0x010, then load 0x010 (RAM model with 1-cycle latency) -> `mem_we` pulses once; `rd_data` = 0xDEAD with `rd_valid` the cycle after the load.
- Set `phys_in` ch0 = 0x5 -> a level read of 0x3ef returns 0x5 no earlier than 2 edges after the change; an event read of 0x3df returns 0x5, and a second event read returns 0x0.
- Raise bit 1 of ch0 in the same cycle an event read of 0x3df clears a prior event on bit 0 -> that read returns the old bit 0 event (plus bit 1 only if its event sets that cycle); the following read returns 0x2.
- Store to 0x3ef, then load 0x3c5 -> each access gives one `io_err` pulse; `out_data` unchanged; the load returns 0 with `rd_valid`. Simultaneous wr_en+rd_en to 0x3ff -> write occurs, no `rd_valid`.
- Assert `rst` low asynchronously mid-way through a load to 0x3ef -> `rd_valid`, `rd_data`, `out_data` and `evt` go to 0 without waiting for a clock edge.
